codec_slave: RTL and testbench



---
 rtl/codec_slave_if.sv | 11 +
 rtl/codec_slave.sv | 143 ++++++++++++++
 tb/tb_codec_slave.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/codec_slave_if.sv
// I2S pin bundle between the equalizer core (master) and the CODEC responder (slave).
interface codec_slave_if;
    logic RSTn;
    logic SCLK;
    logic LRCLK;
    logic SDin;
    logic SDout;

    modport master (output RSTn, output SCLK, output LRCLK, output SDin, input SDout);
    modport slave  (input RSTn, input SCLK, input LRCLK, input SDin, output SDout);
endinterface

// File: rtl/codec_slave.sv
// I2S CODEC-side responder: oversamples the core's pins on clk, deserializes rx words, serializes tx words.
// Optional LOOPBACK_EN: transmit the last received pair instead of tx_lft/tx_rht.
module codec_slave #(
    parameter int DW   = 24,
    parameter int SLOT = 32
) (
    input  logic          clk,
    input  logic          rst,
    codec_slave_if.slave  i2s,
    input  logic [DW-1:0] tx_lft,
    input  logic [DW-1:0] tx_rht,
    output logic [DW-1:0] rx_lft,
    output logic [DW-1:0] rx_rht,
    output logic          rx_vld,
    output logic          frm_err
);

    localparam int CW = $clog2(SLOT + 2);
    localparam logic [CW-1:0] SLOT_C = CW'(SLOT);
    localparam logic [CW-1:0] DW_C   = CW'(DW);
    localparam logic [CW-1:0] SAT_C  = CW'(SLOT + 1);

    localparam logic [1:0] ST_RESET     = 2'd0;
    localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
    localparam logic [1:0] ST_LEFT      = 2'd2;
    localparam logic [1:0] ST_RIGHT     = 2'd3;

    logic [1:0]    rstn_s, sdin_s;
    logic [2:0]    sclk_s, lrclk_s;
    logic          sclk_rise, sclk_fall, lr_rise, lr_fall;
    logic [1:0]    state;
    logic [CW-1:0] rise_cnt, fall_cnt, rise_inc, fall_inc;
    logic [DW-1:0] rx_sh, rx_hold, rx_nxt;
    logic [DW-1:0] tx_sh, tx_rht_q, src_l, src_r;
    logic          in_frame, frame_edge;

`ifdef LOOPBACK_EN
    logic unused_tx;
    assign unused_tx = ^{tx_lft, tx_rht};
    assign src_l = rx_lft;
    assign src_r = rx_rht;
`else
    assign src_l = tx_lft;
    assign src_r = tx_rht;
`endif

    // Edge pulses are registered so every pin event reaches the FSM a fixed 3 clk after the pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstn_s    <= '0;
            sdin_s    <= '0;
            sclk_s    <= '0;
            lrclk_s   <= '0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            lr_rise   <= 1'b0;
            lr_fall   <= 1'b0;
        end else begin
            rstn_s    <= {rstn_s[0], i2s.RSTn};
            sdin_s    <= {sdin_s[0], i2s.SDin};
            sclk_s    <= {sclk_s[1:0], i2s.SCLK};
            lrclk_s   <= {lrclk_s[1:0], i2s.LRCLK};
            sclk_rise <= sclk_s[1] & ~sclk_s[2];
            sclk_fall <= ~sclk_s[1] & sclk_s[2];
            lr_rise   <= lrclk_s[1] & ~lrclk_s[2];
            lr_fall   <= ~lrclk_s[1] & lrclk_s[2];
        end
    end

    assign in_frame   = (state == ST_LEFT) || (state == ST_RIGHT);
    assign frame_edge = (in_frame && (lr_rise || lr_fall)) || ((state == ST_WAIT_SYNC) && lr_fall);
    assign rise_inc   = (rise_cnt == SAT_C) ? rise_cnt : rise_cnt + CW'(1);
    assign fall_inc   = (fall_cnt == SAT_C) ? fall_cnt : fall_cnt + CW'(1);
    assign rx_nxt     = {rx_sh[DW-2:0], sdin_s[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RESET;
            rise_cnt  <= '0;
            fall_cnt  <= '0;
            rx_sh     <= '0;
            rx_hold   <= '0;
            tx_sh     <= '0;
            tx_rht_q  <= '0;
            rx_lft    <= '0;
            rx_rht    <= '0;
            rx_vld    <= 1'b0;
            frm_err   <= 1'b0;
            i2s.SDout <= 1'b0;
        end else begin
            rx_vld <= 1'b0;
            if (!rstn_s[1]) begin
                state     <= ST_RESET;
                frm_err   <= 1'b0;
                rise_cnt  <= '0;
                fall_cnt  <= '0;
                i2s.SDout <= 1'b0;
            end else if (frame_edge) begin
                // LRCLK edge wins over a coincident SCLK fall; that fall is not counted.
                if (in_frame && (rise_cnt != SLOT_C))
                    frm_err <= 1'b1;
                state     <= lr_fall ? ST_LEFT : ST_RIGHT;
                rise_cnt  <= '0;
                fall_cnt  <= '0;
                i2s.SDout <= 1'b0;
                if (lr_fall) begin
                    tx_sh    <= src_l;
                    tx_rht_q <= src_r;
                end else begin
                    tx_sh <= tx_rht_q;
                end
            end else if (state == ST_RESET) begin
                state <= ST_WAIT_SYNC;
            end else if (in_frame) begin
                if (sclk_rise) begin
                    rise_cnt <= rise_inc;
                    if ((rise_cnt != '0) && (rise_cnt <= DW_C)) begin
                        rx_sh <= rx_nxt;
                        if (rise_cnt == DW_C) begin
                            if (state == ST_LEFT) begin
                                rx_hold <= rx_nxt;
                            end else begin
                                rx_lft <= rx_hold;
                                rx_rht <= rx_nxt;
                                rx_vld <= 1'b1;
                            end
                        end
                    end
                end
                if (sclk_fall) begin
                    fall_cnt <= fall_inc;
                    if (fall_inc <= DW_C) begin
                        i2s.SDout <= tx_sh[DW-1];
                        tx_sh     <= {tx_sh[DW-2:0], 1'b0};
                    end else begin
                        i2s.SDout <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_codec_slave.sv
// Directed bench for codec_slave: drives I2S pins as the core would and checks rx/tx words and error flag.
module tb_codec_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] tx_lft, tx_rht, rx_lft, rx_rht;
    logic        rx_vld, frm_err;

    codec_slave_if bus ();

    codec_slave #(.DW(24), .SLOT(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .i2s     (bus),
        .tx_lft  (tx_lft),
        .tx_rht  (tx_rht),
        .rx_lft  (rx_lft),
        .rx_rht  (rx_rht),
        .rx_vld  (rx_vld),
        .frm_err (frm_err)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int vld_cnt = 0;

    always @(negedge clk)
        if (rx_vld === 1'b1) vld_cnt++;

    logic [23:0] el, er, ml, mr, gl, gr;
    logic        z1, z2, o1, o2, any1;
    int          v0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Words the DUT should be transmitting in the frame about to start.
    task automatic expect_tx();
`ifdef LOOPBACK_EN
        el = ml;
        er = mr;
`else
        el = tx_lft;
        er = tx_rht;
`endif
    endtask

    // One half-frame of n SCLK periods; LRCLK and SDin change on SCLK falls, SDout sampled at rises.
    task automatic half(input logic lr, input logic [23:0] w, input int n, input int stop,
                        output logic [23:0] got, output logic zok, output logic ones);
        logic [23:0] wv;
        wv = w;
        got = '0;
        zok = 1'b1;
        ones = 1'b0;
        bus.SCLK = 1'b0;
        bus.LRCLK = lr;
        bus.SDin = 1'b0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            bus.SCLK = 1'b1;
            if (bus.SDout === 1'b1) ones = 1'b1;
            if (k >= 1 && k <= 24) got[24-k] = bus.SDout;
            else if (bus.SDout !== 1'b0) zok = 1'b0;
            repeat (8) @(negedge clk);
            if (k == stop) return;
            if (k < n - 1) begin
                bus.SCLK = 1'b0;
                bus.SDin = (k + 1 <= 24) ? wv[23-k] : 1'b1;
                repeat (8) @(negedge clk);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.RSTn = 1'b0;
        bus.SCLK = 1'b1;
        bus.LRCLK = 1'b1;
        bus.SDin = 1'b0;
        tx_lft = 24'h800001;
        tx_rht = 24'h7FFFFE;
        ml = '0;
        mr = '0;
        repeat (4) @(negedge clk);
        chk("reset_sdout", {31'd0, bus.SDout}, 32'd0);
        chk("reset_rx_lft", {8'd0, rx_lft}, 32'd0);
        chk("reset_rx_rht", {8'd0, rx_rht}, 32'd0);
        chk("reset_rx_vld", {31'd0, rx_vld}, 32'd0);
        chk("reset_frm_err", {31'd0, frm_err}, 32'd0);

        // RSTn held low for 10 frames while the clocks run
        rst = 1'b0;
        v0 = vld_cnt;
        any1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            half(1'b0, 24'hA5F00F, 32, -1, gl, z1, o1);
            half(1'b1, 24'h123456, 32, -1, gr, z2, o2);
            any1 = any1 | o1 | o2;
        end
        chk("rstn_low_sdout", {31'd0, any1}, 32'd0);
        chk("rstn_low_vld", vld_cnt - v0, 32'd0);
        chk("rstn_low_err", {31'd0, frm_err}, 32'd0);

        // First frame after release
        bus.RSTn = 1'b1;
        repeat (6) @(negedge clk);
        expect_tx();
        v0 = vld_cnt;
        half(1'b0, 24'hA5F00F, 32, -1, gl, z1, o1);
        half(1'b1, 24'h123456, 32, -1, gr, z2, o2);
        chk("f1_vld_cnt", vld_cnt - v0, 32'd1);
        chk("f1_rx_lft", {8'd0, rx_lft}, 32'hA5F00F);
        chk("f1_rx_rht", {8'd0, rx_rht}, 32'h123456);
        chk("f1_tx_lft", {8'd0, gl}, {8'd0, el});
        chk("f1_tx_rht", {8'd0, gr}, {8'd0, er});
        chk("f1_tx_idle0", {31'd0, z1 & z2}, 32'd1);
        chk("f1_frm_err", {31'd0, frm_err}, 32'd0);
        ml = 24'hA5F00F;
        mr = 24'h123456;

        // Second frame, different data both ways
        tx_lft = 24'hFFFFFF;
        tx_rht = 24'h000000;
        expect_tx();
        v0 = vld_cnt;
        half(1'b0, 24'h5A0FF0, 32, -1, gl, z1, o1);
        half(1'b1, 24'hEDCBA9, 32, -1, gr, z2, o2);
        chk("f2_vld_cnt", vld_cnt - v0, 32'd1);
        chk("f2_rx_lft", {8'd0, rx_lft}, 32'h5A0FF0);
        chk("f2_rx_rht", {8'd0, rx_rht}, 32'hEDCBA9);
        chk("f2_tx_lft", {8'd0, gl}, {8'd0, el});
        chk("f2_tx_rht", {8'd0, gr}, {8'd0, er});
        chk("f2_tx_idle0", {31'd0, z1 & z2}, 32'd1);
        ml = 24'h5A0FF0;
        mr = 24'hEDCBA9;

        // Short left half-frame (31 SCLK periods) -> sticky error
        half(1'b0, 24'h0F0F0F, 31, -1, gl, z1, o1);
        half(1'b1, 24'hF0F0F0, 32, -1, gr, z2, o2);
        chk("short_err_set", {31'd0, frm_err}, 32'd1);
        ml = 24'h0F0F0F;
        mr = 24'hF0F0F0;
        half(1'b0, 24'h333333, 32, -1, gl, z1, o1);
        half(1'b1, 24'h444444, 32, -1, gr, z2, o2);
        chk("short_err_sticky", {31'd0, frm_err}, 32'd1);
        chk("after_err_rx_lft", {8'd0, rx_lft}, 32'h333333);
        ml = 24'h333333;
        mr = 24'h444444;
        bus.RSTn = 1'b0;
        repeat (6) @(negedge clk);
        chk("rstn_clears_err", {31'd0, frm_err}, 32'd0);
        bus.RSTn = 1'b1;
        repeat (6) @(negedge clk);

        // Re-sync frame, then rst at right-half index 12
        half(1'b0, 24'h555555, 32, -1, gl, z1, o1);
        half(1'b1, 24'h666666, 32, -1, gr, z2, o2);
        ml = 24'h555555;
        mr = 24'h666666;
        tx_rht = 24'hFFFFFF;
        half(1'b0, 24'h777777, 32, -1, gl, z1, o1);
        half(1'b1, 24'h888888, 32, 12, gr, z2, o2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sdout", {31'd0, bus.SDout}, 32'd0);
        chk("midrst_rx_lft", {8'd0, rx_lft}, 32'd0);
        chk("midrst_rx_rht", {8'd0, rx_rht}, 32'd0);
        chk("midrst_rx_vld", {31'd0, rx_vld}, 32'd0);
        chk("midrst_frm_err", {31'd0, frm_err}, 32'd0);
        rst = 1'b0;
        ml = '0;
        mr = '0;
        v0 = vld_cnt;
        half(1'b1, 24'h999999, 32, -1, gr, z2, o2);
        tx_lft = 24'h800001;
        tx_rht = 24'h7FFFFE;
        expect_tx();
        half(1'b0, 24'hC0FFEE, 32, -1, gl, z1, o1);
        half(1'b1, 24'h0BEEF0, 32, -1, gr, z2, o2);
        chk("resync_vld_cnt", vld_cnt - v0, 32'd1);
        chk("resync_rx_lft", {8'd0, rx_lft}, 32'hC0FFEE);
        chk("resync_rx_rht", {8'd0, rx_rht}, 32'h0BEEF0);
        chk("resync_tx_lft", {8'd0, gl}, {8'd0, el});
        chk("resync_tx_rht", {8'd0, gr}, {8'd0, er});
        chk("resync_tx_idle0", {31'd0, z1 & z2}, 32'd1);
        ml = 24'hC0FFEE;
        mr = 24'h0BEEF0;

        // Next frame: in loopback builds SDout carries the pair received above
        tx_lft = 24'h13579B;
        tx_rht = 24'h2468AC;
        expect_tx();
        half(1'b0, 24'h000000, 32, -1, gl, z1, o1);
        half(1'b1, 24'hFFFFFF, 32, -1, gr, z2, o2);
        chk("last_tx_lft", {8'd0, gl}, {8'd0, el});
        chk("last_tx_rht", {8'd0, gr}, {8'd0, er});
        chk("last_tx_idle0", {31'd0, z1 & z2}, 32'd1);
        chk("last_rx_lft", {8'd0, rx_lft}, 32'h000000);
        chk("last_rx_rht", {8'd0, rx_rht}, 32'hFFFFFF);
        chk("last_frm_err", {31'd0, frm_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
